// File: rtl/arb_pkg.sv
// Shared definitions for the memory bus arbiter: owner/state encodings,
// request-vector priority indices and the owner-to-grant mapping.
package arb_pkg;

    typedef enum logic [1:0] {
        OWN_DMA  = 2'd0,
        OWN_BLIT = 2'd1,
        OWN_GPU  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } state_e;

    // Bit positions in the request vector; lower index means higher priority.
    localparam int unsigned NUM_REQ      = 5;
    localparam int unsigned PRIO_DMA     = 0;
    localparam int unsigned PRIO_BLIT_HI = 1;
    localparam int unsigned PRIO_GPU     = 2;
    localparam int unsigned PRIO_BLIT_LO = 3;
    localparam int unsigned PRIO_CPU     = 4;

    typedef logic [NUM_REQ-1:0] req_t;

    // Grant vector ordering: {dma, blit, gpu, cpu}
    typedef logic [3:0] grant_t;

    function automatic grant_t grant_of(input owner_e owner);
        return grant_t'(4'b1000 >> owner);
    endfunction

endpackage

// File: rtl/arb_prio_enc.sv
// Combinational priority encoder: picks the winning bus master from the
// request vector, lifting the CPU above GPU and low blitter when starved.
module arb_prio_enc
    import arb_pkg::*;
(
    input  req_t   req_i,
    input  logic   starve_i,
    output logic   valid_o,
    output owner_e owner_o
);

    always_comb begin
        // NOTE: every output gets a default before the decision chain, so no
        // path leaves it unassigned and no latch is inferred.
        valid_o = |req_i;
        owner_o = OWN_CPU;
        if (req_i[PRIO_DMA]) begin
            owner_o = OWN_DMA;
        end else if (req_i[PRIO_BLIT_HI]) begin
            owner_o = OWN_BLIT;
        end else if (starve_i && req_i[PRIO_CPU]) begin
            owner_o = OWN_CPU;
        end else if (req_i[PRIO_GPU]) begin
            owner_o = OWN_GPU;
        end else if (req_i[PRIO_BLIT_LO]) begin
            owner_o = OWN_BLIT;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Five-requester memory bus arbiter with a parked CPU grant, a one-cycle
// turnaround between owners, lock/busy-protected ownership and CPU anti-starvation.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic dma_breq,
    input  logic blit_breq_1,
    input  logic gpu_breq,
    input  logic blit_breq_0,
    input  logic cpu_breq,
    input  logic lock,
    input  logic mreq,
    input  logic ack,
    output logic dma_back,
    output logic blit_back,
    output logic gpu_back,
    output logic cpu_back,
    output logic busy
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    grant_t     grant_q, grant_d;
    logic       busy_q, busy_d;
    logic [7:0] starve_cnt_q, starve_cnt_d;

    req_t   req;
    logic   starve;
    logic   win_valid;
    owner_e win_owner;
    logic   owner_req;
    logic   may_switch;

    assign req = {cpu_breq, blit_breq_0, gpu_breq, blit_breq_1, dma_breq};
    assign starve = (starve_cnt_q >= LIMIT);

    arb_prio_enc u_prio_enc (
        .req_i   (req),
        .starve_i(starve),
        .valid_o (win_valid),
        .owner_o (win_owner)
    );

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            OWN_DMA:  owner_req = req[PRIO_DMA];
            OWN_BLIT: owner_req = req[PRIO_BLIT_HI] | req[PRIO_BLIT_LO];
            OWN_GPU:  owner_req = req[PRIO_GPU];
            OWN_CPU:  owner_req = req[PRIO_CPU];
            default:  owner_req = 1'b0;
        endcase
    end

    // Ownership may only change at a quiet boundary; a pending winner that is
    // blocked here is simply re-evaluated next cycle, so preemption is deferred.
    assign may_switch = !lock && !busy_q && !mreq;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            ST_IDLE, ST_TURN: begin
                if (win_valid) begin
                    state_d = ST_OWN;
                    owner_d = win_owner;
                end else begin
                    state_d = ST_IDLE;
                    owner_d = OWN_CPU;
                end
            end
            ST_OWN: begin
                // With the owner still requesting, any different winner is
                // strictly higher priority, so that alone signals preemption.
                if (may_switch && (!owner_req || win_owner != owner_q)) begin
                    state_d = ST_TURN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_CPU;
            end
        endcase

        case (state_d)
            ST_OWN:  grant_d = grant_of(owner_d);
            ST_TURN: grant_d = '0;
            default: grant_d = grant_of(OWN_CPU);
        endcase

        busy_d = busy_q ? !ack : (mreq && !ack);

        starve_cnt_d = starve_cnt_q;
        if (state_d == ST_OWN && owner_d == OWN_CPU) begin
            starve_cnt_d = '0;
        end else if (cpu_breq && starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            grant_q      <= grant_of(OWN_CPU);
            busy_q       <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign {dma_back, blit_back, gpu_back, cpu_back} = grant_q;
    assign busy = busy_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-low, with ports named clk and reset_n.
REQ-002 The parameter STARVE_LIMIT SHALL default to 16 and give the cycles cpu_breq may wait before promotion (legal range 2..255).
REQ-003 clk, input, 1: system clock; all state changes on rising edge.
REQ-004 reset_n, input, 1: asynchronous active-low reset.
REQ-005 dma_breq, input, 1: DMA/object-processor bus request (priority 0, highest).
REQ-006 blit_breq_1, input, 1: blitter high-priority request (priority 1).
REQ-007 gpu_breq, input, 1: GPU bus request (priority 2).
REQ-008 blit_breq_0, input, 1: blitter low-priority request (priority 3).
REQ-009 cpu_breq, input, 1: 68000 bus request (priority 4, default owner).
REQ-010 lock, input, 1: the current owner forbids preemption while high.
REQ-011 mreq, input, 1: single-cycle pulse marking the start of a memory transfer by the current owner.
REQ-012 ack, input, 1: single-cycle pulse marking the end of the transfer in progress.
REQ-013 dma_back, blit_back, gpu_back, cpu_back, output, 1 each: bus grants; at most one is high.
REQ-014 busy, output, 1: a transfer is in progress (mreq seen, ack not yet seen).

Function
REQ-015 busy SHALL set on the cycle after mreq and clear on the cycle after ack; when mreq and ack coincide, busy SHALL stay 0.
REQ-016 States SHALL be IDLE, OWN and TURN; OWN SHALL record the owner as DMA, BLIT, GPU or CPU.
REQ-017 In IDLE with no request, cpu_back SHALL be driven high (parked grant) and the state SHALL remain IDLE.
REQ-018 In IDLE with a request, the highest-priority requester SHALL be granted on the next cycle (grant latency 1 cycle), and the state SHALL become OWN.
REQ-019 blit_back SHALL be granted for either blitter request; the effective priority is that of the highest blitter request currently asserted.
REQ-020 In OWN, the grant SHALL hold while the owner's request is high, or while lock is high, or while busy/mreq is high.
REQ-021 In OWN, when the owner's request drops, lock is low, busy is 0 and mreq is 0, the state SHALL go to TURN with all grants low.
REQ-022 In OWN, when a strictly higher-priority request is pending, lock is low, busy is 0 and mreq is 0, the arbiter SHALL preempt by moving to TURN.
REQ-023 TURN SHALL last exactly 1 cycle with all backs low, then SHALL arbitrate as in IDLE.
REQ-024 A starvation counter (8 bits) SHALL increment each cycle that cpu_breq is high while CPU is not the owner, and SHALL clear when CPU is granted.
REQ-025 When the counter reaches STARVE_LIMIT, CPU priority SHALL be raised above GPU and blit_breq_0 (still below DMA and blit_breq_1) until CPU is granted; the counter SHALL saturate at STARVE_LIMIT.
REQ-026 If a request and lock are both high when owner changes are blocked, lock SHALL win; preemption SHALL be deferred, never dropped.
REQ-027 An ack received while busy=0 SHALL be ignored.
REQ-028 A mreq from a non-owner SHALL NOT be detectable; the arbiter SHALL treat mreq as the owner's.

Reset
REQ-029 While reset_n is low, the state SHALL be IDLE, busy SHALL be 0, the counter SHALL be 0, cpu_back SHALL be 1 and all other backs SHALL be 0.
REQ-030 When reset is asserted mid-transfer, reset SHALL abort the transfer immediately, with no ack required.
REQ-031 On deassertion, arbitration SHALL begin on the first rising edge.

Structure
REQ-032 The owner encoding (DMA, BLIT, GPU, CPU) and the priority indices SHALL reside in a shared package, arb_pkg.
REQ-033 The design SHALL consist of one sub-module, arb_prio_enc, a combinational priority encoder taking the request vector and the starve flag; the state machine SHALL stay in mem_arbiter.

Verification
REQ-034 Reset release, then gpu_breq=1 at cycle 0 -> gpu_back=1 at cycle 1, cpu_back=0.
REQ-035 GPU owns, busy=1, dma_breq rises -> no switch until the cycle after ack; then 1 TURN cycle, then dma_back=1.
REQ-036 GPU owns, lock=1, dma_breq=1 held for 20 cycles -> gpu_back stays 1; lock drops -> TURN, then dma_back.
REQ-037 blit_breq_0 held continuously while cpu_breq=1, STARVE_LIMIT=16 -> after the 16th waiting cycle, the next idle boundary yields TURN then cpu_back=1, and the counter reads 0.
REQ-038 mreq and ack in the same cycle -> busy remains 0; a stray ack with busy=0 -> no state change.
REQ-039 reset_n pulsed low while busy=1 and dma_back=1 -> in the same cycle, cpu_back=1, busy=0 and dma_back=0.
